// File: rtl/stack_ctrl.sv
// Stack-access sequencer: turns PUSH/POP/CALL/RET/INTR/RTI requests into
// single-port data-memory cycles plus regfile SP increment/decrement strobes.
module stack_ctrl #(
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [7:0]        push_data,
  input  logic [7:0]        pc_in,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [7:0]        sp_in,
  output logic [7:0]        mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              dec_sp,
  output logic              inc_sp,
  output logic [7:0]        pop_data,
  output logic              pop_valid,
  output logic [7:0]        pc_out,
  output logic              pc_load,
  output logic [FLAG_W-1:0] flags_out,
  output logic              flags_load,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_CALL = 3'b010;
  localparam logic [2:0] OP_RET  = 3'b011;
  localparam logic [2:0] OP_INTR = 3'b100;
  localparam logic [2:0] OP_RTI  = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE, S_WR1, S_WR2, S_RD1, S_RD2, S_RD3, S_FIN, S_ERR
  } state_t;

  state_t            state_q;
  logic [2:0]        op_q;
  logic [FLAG_W-1:0] flags_q;
  logic [7:0]        sp_q;
  logic              req_ready_q;
  logic [7:0]        mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              mem_we_q;
  logic              mem_re_q;
  logic              dec_sp_q;
  logic              inc_sp_q;
  logic              pop_valid_q;
  logic              pc_load_q;
  logic              flags_load_q;
  logic              done_q;
  logic              err_q;

  // sp_q tracks the stack pointer after each strobe already issued, so the
  // next access address is sp_q itself (push side) or sp_q+1 (pop side).
  // State register and the strobes of the state being entered, updated together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= 3'b000;
      flags_q      <= '0;
      sp_q         <= 8'h00;
      req_ready_q  <= 1'b1;
      mem_addr_q   <= 8'h00;
      mem_wdata_q  <= 8'h00;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      dec_sp_q     <= 1'b0;
      inc_sp_q     <= 1'b0;
      pop_valid_q  <= 1'b0;
      pc_load_q    <= 1'b0;
      flags_load_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      req_ready_q  <= 1'b0;
      mem_addr_q   <= 8'h00;
      mem_wdata_q  <= 8'h00;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      dec_sp_q     <= 1'b0;
      inc_sp_q     <= 1'b0;
      pop_valid_q  <= 1'b0;
      pc_load_q    <= 1'b0;
      flags_load_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            op_q    <= req_op;
            flags_q <= flags_in;
            case (req_op)
              OP_PUSH, OP_CALL, OP_INTR: begin
                state_q     <= S_WR1;
                mem_we_q    <= 1'b1;
                dec_sp_q    <= 1'b1;
                mem_addr_q  <= sp_in;
                mem_wdata_q <= (req_op == OP_PUSH) ? push_data : pc_in;
                sp_q        <= sp_in - 8'd1;
              end
              OP_POP, OP_RET, OP_RTI: begin
                state_q    <= S_RD1;
                mem_re_q   <= 1'b1;
                inc_sp_q   <= 1'b1;
                mem_addr_q <= sp_in + 8'd1;
                sp_q       <= sp_in + 8'd1;
              end
              default: begin
                state_q <= S_ERR;
                err_q   <= 1'b1;
                sp_q    <= sp_in;
              end
            endcase
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        S_WR1: begin
          if (op_q == OP_INTR) begin
            state_q     <= S_WR2;
            mem_we_q    <= 1'b1;
            dec_sp_q    <= 1'b1;
            mem_addr_q  <= sp_q;
            mem_wdata_q <= 8'(flags_q);
            sp_q        <= sp_q - 8'd1;
          end else begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
          end
        end
        S_WR2: begin
          state_q <= S_FIN;
          done_q  <= 1'b1;
        end
        S_RD1: begin
          state_q <= S_RD2;
          case (op_q)
            OP_POP: begin
              pop_valid_q <= 1'b1;
              done_q      <= 1'b1;
            end
            OP_RET: begin
              pc_load_q <= 1'b1;
              done_q    <= 1'b1;
            end
            OP_RTI: begin
              flags_load_q <= 1'b1;
              mem_re_q     <= 1'b1;
              inc_sp_q     <= 1'b1;
              mem_addr_q   <= sp_q + 8'd1;
              sp_q         <= sp_q + 8'd1;
            end
            default: begin
              done_q <= 1'b1;
            end
          endcase
        end
        S_RD2: begin
          if (op_q == OP_RTI) begin
            state_q   <= S_RD3;
            pc_load_q <= 1'b1;
            done_q    <= 1'b1;
          end else begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
          end
        end
        S_RD3, S_FIN, S_ERR: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign mem_re     = mem_re_q;
  assign dec_sp     = dec_sp_q;
  assign inc_sp     = inc_sp_q;
  assign pop_valid  = pop_valid_q;
  assign pc_load    = pc_load_q;
  assign flags_load = flags_load_q;
  assign done       = done_q;
  assign err        = err_q;

  // Read data arrives in the cycle its load strobe is high, so it is gated, not registered.
  assign pop_data  = pop_valid_q  ? mem_rdata : 8'h00;
  assign pc_out    = pc_load_q    ? mem_rdata : 8'h00;
  assign flags_out = flags_load_q ? mem_rdata[FLAG_W-1:0] : '0;

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl: directed requests queue their expected
// per-cycle output vectors; a negedge monitor pops and compares them.
module tb_stack_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] push_data, pc_in, sp_in;
  logic [3:0] flags_in;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we, mem_re, dec_sp, inc_sp;
  logic [7:0] pop_data, pc_out;
  logic       pop_valid, pc_load, flags_load, done, err;
  logic [3:0] flags_out;

  logic [7:0] mem [0:255];

  typedef logic [45:0] vec_t;
  vec_t  exp_q [$];
  string tag_q [$];
  int    checks = 0;
  int    fails  = 0;
  bit    mon_en = 1'b0;

  // strobe order: we re dec inc done err pop_valid pc_load flags_load req_ready
  localparam logic [9:0] WE_DEC    = 10'b1010000000;
  localparam logic [9:0] RE_INC    = 10'b0101000000;
  localparam logic [9:0] DONE      = 10'b0000100000;
  localparam logic [9:0] ERR       = 10'b0000010000;
  localparam logic [9:0] PV_DONE   = 10'b0000101000;
  localparam logic [9:0] PL_DONE   = 10'b0000100100;
  localparam logic [9:0] FL_RE_INC = 10'b0101000010;
  localparam logic [9:0] IDLE      = 10'b0000000001;

  always #5 clk = ~clk;

  stack_ctrl #(.FLAG_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .push_data(push_data), .pc_in(pc_in), .flags_in(flags_in),
    .sp_in(sp_in), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .dec_sp(dec_sp), .inc_sp(inc_sp),
    .pop_data(pop_data), .pop_valid(pop_valid), .pc_out(pc_out), .pc_load(pc_load),
    .flags_out(flags_out), .flags_load(flags_load), .done(done), .err(err)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  function automatic vec_t ev(input logic [9:0] s, input logic [7:0] a, input logic [7:0] w,
                              input logic [7:0] pd, input logic [7:0] pc, input logic [3:0] fo);
    return {s, a, w, pd, pc, fo};
  endfunction

  task automatic expect_v(input string t, input vec_t v);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      vec_t  act;
      vec_t  e;
      string t;
      act = {mem_we, mem_re, dec_sp, inc_sp, done, err, pop_valid, pc_load, flags_load,
             req_ready, mem_addr, mem_wdata, pop_data, pc_out, flags_out};
      checks++;
      if (|act[45:37]) begin
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output actual=%h required=none", act);
        end else begin
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          if (act !== e) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", t, act, e);
          end
        end
      end else if (act !== ev(IDLE, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0)) begin
        fails++;
        $display("FAIL idle_outputs actual=%h required=%h", act,
                 ev(IDLE, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0));
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [7:0] sp, input logic [7:0] d,
                       input logic [7:0] pc, input logic [3:0] fl, input bit hold);
    bit got;
    @(negedge clk);
    req_op = op; sp_in = sp; push_data = d; pc_in = pc; flags_in = fl;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    if (hold) req_op = 3'b111;
    else req_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (done || err) begin
        got = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (!got) begin
      fails++;
      $display("FAIL completion_timeout op=%b actual=none required=done_or_err", op);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=hung required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 3'b000;
    push_data = 8'h00; pc_in = 8'h00; flags_in = 4'h0; sp_in = 8'h00;
    repeat (2) @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    expect_v("push_wr1",  ev(WE_DEC, 8'h80, 8'h5A, 8'h00, 8'h00, 4'h0));
    expect_v("push_done", ev(DONE,   8'h00, 8'h00, 8'h00, 8'h00, 4'h0));
    issue(3'b000, 8'h80, 8'h5A, 8'h00, 4'h0, 1'b0);

    expect_v("call_wr1",  ev(WE_DEC, 8'h20, 8'h77, 8'h00, 8'h00, 4'h0));
    expect_v("call_done", ev(DONE,   8'h00, 8'h00, 8'h00, 8'h00, 4'h0));
    issue(3'b010, 8'h20, 8'h00, 8'h77, 4'h0, 1'b0);

    expect_v("intr_wr1",  ev(WE_DEC, 8'h10, 8'h33, 8'h00, 8'h00, 4'h0));
    expect_v("intr_wr2",  ev(WE_DEC, 8'h0F, 8'h0B, 8'h00, 8'h00, 4'h0));
    expect_v("intr_done", ev(DONE,   8'h00, 8'h00, 8'h00, 8'h00, 4'h0));
    issue(3'b100, 8'h10, 8'h00, 8'h33, 4'hB, 1'b0);

    expect_v("rti_rd1",   ev(RE_INC,    8'h0F, 8'h00, 8'h00, 8'h00, 4'h0));
    expect_v("rti_flags", ev(FL_RE_INC, 8'h10, 8'h00, 8'h00, 8'h00, 4'hB));
    expect_v("rti_pc",    ev(PL_DONE,   8'h00, 8'h00, 8'h00, 8'h33, 4'h0));
    issue(3'b101, 8'h0E, 8'h00, 8'h00, 4'h0, 1'b0);

    expect_v("push_wrap_wr1",  ev(WE_DEC, 8'h00, 8'hC4, 8'h00, 8'h00, 4'h0));
    expect_v("push_wrap_done", ev(DONE,   8'h00, 8'h00, 8'h00, 8'h00, 4'h0));
    issue(3'b000, 8'h00, 8'hC4, 8'h00, 4'h0, 1'b0);

    expect_v("pop_wrap_rd1", ev(RE_INC,  8'h00, 8'h00, 8'h00, 8'h00, 4'h0));
    expect_v("pop_wrap_rd2", ev(PV_DONE, 8'h00, 8'h00, 8'hC4, 8'h00, 4'h0));
    issue(3'b001, 8'hFF, 8'h00, 8'h00, 4'h0, 1'b0);

    expect_v("ret_rd1", ev(RE_INC,  8'h20, 8'h00, 8'h00, 8'h00, 4'h0));
    expect_v("ret_rd2", ev(PL_DONE, 8'h00, 8'h00, 8'h00, 8'h77, 4'h0));
    issue(3'b011, 8'h1F, 8'h00, 8'h00, 4'h0, 1'b0);

    expect_v("illegal_111", ev(ERR, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0));
    issue(3'b111, 8'h44, 8'h00, 8'h00, 4'h0, 1'b0);
    expect_v("illegal_110", ev(ERR, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0));
    issue(3'b110, 8'h44, 8'h00, 8'h00, 4'h0, 1'b0);

    expect_v("push_busy_wr1",  ev(WE_DEC, 8'h55, 8'hA5, 8'h00, 8'h00, 4'h0));
    expect_v("push_busy_done", ev(DONE,   8'h00, 8'h00, 8'h00, 8'h00, 4'h0));
    issue(3'b000, 8'h55, 8'hA5, 8'h00, 4'h0, 1'b1);

    // reset lands on the edge that would enter WR2
    expect_v("intr_rst_wr1", ev(WE_DEC, 8'h40, 8'h99, 8'h00, 8'h00, 4'h0));
    @(negedge clk);
    req_op = 3'b100; sp_in = 8'h40; pc_in = 8'h99; flags_in = 4'h5; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    expect_v("pop_after_rst_rd1", ev(RE_INC,  8'h80, 8'h00, 8'h00, 8'h00, 4'h0));
    expect_v("pop_after_rst_rd2", ev(PV_DONE, 8'h00, 8'h00, 8'h5A, 8'h00, 4'h0));
    issue(3'b001, 8'h7F, 8'h00, 8'h00, 4'h0, 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_outputs actual=%0d_left required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
